// File: rtl/ice40_reset_ctrl.sv
// System reset manager for main_6502: power-on delay, debounced button and watchdog,
// stretched to a minimum width, released synchronously, with the last cause reported.
module ice40_reset_ctrl #(
    parameter int unsigned FPGAClkSpeed     = 12000000,
    parameter int unsigned PorCycles        = 4096,
    parameter int unsigned HoldCycles       = 256,
    parameter int unsigned DebounceCycles   = 120000,
    parameter int unsigned WdtTimeoutCycles = 12000000,
    parameter int unsigned SyncStages       = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        btn_i,
    input  logic        wdt_en_i,
    input  logic        wdt_kick_i,
    output logic        sys_reset_o,
    output logic [1:0]  reset_cause_o,
    output logic [23:0] wdt_count_o
);

    localparam int unsigned SyncN    = (SyncStages < 2) ? 2 : SyncStages;
    localparam int unsigned PhaseMax = (PorCycles > HoldCycles) ? PorCycles : HoldCycles;
    localparam int unsigned CntW     = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;
    localparam int unsigned DbW      = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam int unsigned WdtW     = (WdtTimeoutCycles > 1) ? $clog2(WdtTimeoutCycles) : 1;

    localparam logic [CntW-1:0] POR_LAST  = CntW'(PorCycles - 1);
    localparam logic [CntW-1:0] HOLD_LAST = CntW'(HoldCycles - 1);
    localparam logic [DbW-1:0]  DB_LAST   = DbW'(DebounceCycles - 1);
    localparam logic [WdtW-1:0] WDT_LAST  = WdtW'(WdtTimeoutCycles - 1);

    localparam logic [1:0] ST_POR  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    if (FPGAClkSpeed == 0 || SyncStages < 2) begin : g_param_check
        $error("ice40_reset_ctrl: FPGAClkSpeed must be nonzero and SyncStages >= 2");
    end

    logic [SyncN-1:0] sync_q;
    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             db_q, db_d;
    logic [WdtW-1:0]  wdt_q, wdt_d;
    logic [1:0]       cause_q, cause_d;
    logic             sys_reset_d;
    logic             btn_sync;
    logic             wdt_expire;

    assign btn_sync = sync_q[SyncN-1];

    // State register; everything returns to power-on values while reset_i is high.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q      <= '0;
            state_q     <= ST_POR;
            cnt_q       <= '0;
            db_cnt_q    <= '0;
            db_q        <= 1'b0;
            wdt_q       <= '0;
            cause_q     <= CAUSE_POR;
            sys_reset_o <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SyncN-2:0], btn_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            db_cnt_q    <= db_cnt_d;
            db_q        <= db_d;
            wdt_q       <= wdt_d;
            cause_q     <= cause_d;
            sys_reset_o <= sys_reset_d;
        end
    end

    // Debouncer, phase FSM and watchdog next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        db_cnt_d    = '0;
        db_d        = db_q;
        wdt_d       = '0;
        wdt_expire  = 1'b0;
        sys_reset_d = 1'b1;

        if (btn_sync != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end

        // A kick on the terminal count wins over expiry.
        wdt_expire = (state_q == ST_RUN) && wdt_en_i && !wdt_kick_i && (wdt_q == WDT_LAST);

        case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_POR;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_HOLD: begin
                // Saturate at the terminal count while the button is still held.
                if (cnt_q == HOLD_LAST) begin
                    if (!db_q) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_RUN: begin
                // The debounced level is always low on entry, so high here means a new press.
                if (db_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_BTN;
                end else if (wdt_expire) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_WDT;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
            end
        endcase

        if ((state_q == ST_RUN) && (state_d == ST_RUN) && wdt_en_i && !wdt_kick_i) begin
            wdt_d = wdt_q + WdtW'(1);
        end

        sys_reset_d = (state_d != ST_RUN);
    end

    assign reset_cause_o = cause_q;
    assign wdt_count_o   = 24'(wdt_q);

endmodule

// File: tb/tb_ice40_reset_ctrl.sv
// Directed bench for ice40_reset_ctrl with small parameters; expected values are
// hand-derived edge counts for each scenario.
module tb_ice40_reset_ctrl;

    logic        clk_i;
    logic        reset_i;
    logic        btn_i;
    logic        wdt_en_i;
    logic        wdt_kick_i;
    logic        sys_reset_o;
    logic [1:0]  reset_cause_o;
    logic [23:0] wdt_count_o;

    int vectors;
    int miscompares;

    ice40_reset_ctrl #(
        .FPGAClkSpeed     (12000000),
        .PorCycles        (16),
        .HoldCycles       (8),
        .DebounceCycles   (4),
        .WdtTimeoutCycles (32),
        .SyncStages       (2)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .btn_i         (btn_i),
        .wdt_en_i      (wdt_en_i),
        .wdt_kick_i    (wdt_kick_i),
        .sys_reset_o   (sys_reset_o),
        .reset_cause_o (reset_cause_o),
        .wdt_count_o   (wdt_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_i     = 1'b1;
        btn_i       = 1'b0;
        wdt_en_i    = 1'b0;
        wdt_kick_i  = 1'b0;

        // Power-up: 5 cycles of reset, then release after exactly 24 edges.
        repeat (5) @(posedge clk_i);
        #2;
        check("rst_sys", 32'(sys_reset_o), 32'd1);
        check("rst_cause", 32'(reset_cause_o), 32'd0);
        check("rst_wdt", 32'(wdt_count_o), 32'd0);
        reset_i = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("por_sys", 32'(sys_reset_o), (i < 24) ? 32'd1 : 32'd0);
        end
        check("por_cause", 32'(reset_cause_o), 32'd0);

        // Bounce rejection: 2-cycle runs never reach the 4-cycle debounce.
        for (int i = 0; i < 40; i++) begin
            btn_i = (((i >> 1) & 1) == 0);
            tick();
            check("bounce_sys", 32'(sys_reset_o), 32'd0);
        end
        btn_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bounce_idle", 32'(sys_reset_o), 32'd0);
        end
        check("bounce_cause", 32'(reset_cause_o), 32'd0);

        // Button reset: rises on edge 7, held while pressed, falls 7 edges after release.
        btn_i = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            check("btn_press", 32'(sys_reset_o), (i >= 7) ? 32'd1 : 32'd0);
        end
        btn_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("btn_release", 32'(sys_reset_o), (i < 7) ? 32'd1 : 32'd0);
        end
        check("btn_cause", 32'(reset_cause_o), 32'd1);
        check("btn_wdt", 32'(wdt_count_o), 32'd0);

        // Watchdog timeout: count 1..31, expiry on the next edge, 8-edge hold.
        wdt_en_i = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check("wdt_count", 32'(wdt_count_o), 32'(i));
            check("wdt_run", 32'(sys_reset_o), 32'd0);
        end
        tick();
        check("wdt_expire_sys", 32'(sys_reset_o), 32'd1);
        check("wdt_expire_cnt", 32'(wdt_count_o), 32'd0);
        check("wdt_expire_cause", 32'(reset_cause_o), 32'd2);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("wdt_hold_sys", 32'(sys_reset_o), 32'd1);
            check("wdt_hold_cnt", 32'(wdt_count_o), 32'd0);
        end
        tick();
        check("wdt_rel_sys", 32'(sys_reset_o), 32'd0);
        check("wdt_rel_cnt", 32'(wdt_count_o), 32'd0);
        check("wdt_rel_cause", 32'(reset_cause_o), 32'd2);

        // Kick exactly at terminal count wins over expiry.
        for (int i = 1; i <= 31; i++) begin
            tick();
            check("kick_ramp", 32'(wdt_count_o), 32'(i));
        end
        wdt_kick_i = 1'b1;
        tick();
        check("kick_tc_cnt", 32'(wdt_count_o), 32'd0);
        check("kick_tc_sys", 32'(sys_reset_o), 32'd0);
        wdt_kick_i = 1'b0;

        // Periodic kicks every 31 cycles keep the system out of reset.
        for (int j = 1; j <= 500; j++) begin
            wdt_kick_i = ((j % 31) == 0);
            tick();
            check("kick_cnt", 32'(wdt_count_o), 32'(j % 31));
            check("kick_sys", 32'(sys_reset_o), 32'd0);
        end
        wdt_kick_i = 1'b0;

        // Disabled watchdog stays at zero.
        wdt_en_i = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            check("wdt_off_cnt", 32'(wdt_count_o), 32'd0);
            check("wdt_off_sys", 32'(sys_reset_o), 32'd0);
        end

        // Async reset during a button-initiated hold restarts the full sequence.
        btn_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("mid_press", 32'(sys_reset_o), (i >= 7) ? 32'd1 : 32'd0);
        end
        check("mid_cause_btn", 32'(reset_cause_o), 32'd1);
        btn_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
        #3;
        check("mid_rst_sys", 32'(sys_reset_o), 32'd1);
        check("mid_rst_cause", 32'(reset_cause_o), 32'd0);
        #2;
        reset_i = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("mid_restart", 32'(sys_reset_o), (i < 24) ? 32'd1 : 32'd0);
        end
        check("mid_final_cause", 32'(reset_cause_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
